// File: rtl/bitty_pkg.sv
// Shared definitions for the Bitty fetch sequencer, assembler and test bench.
package bitty_pkg;

   localparam int unsigned INST_W = 16;

   // Encoding the sequencer treats as "stop here"; it is never issued to the cpu.
   localparam logic [INST_W-1:0] HALT_INST_DEFAULT = 16'hFFFF;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWaitMem,
      StIssue,
      StExec,
      StFault
   } fetch_state_e;

endpackage

// File: rtl/bitty_fetch_ctrl_if.sv
// Instruction-memory read port and cpu issue/retire handshake of the fetch sequencer.
interface bitty_fetch_ctrl_if #(
   parameter int unsigned ADDR_W = 8
);
   import bitty_pkg::*;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [INST_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic [INST_W-1:0] d_inst;
   logic              run;
   logic              done;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;

   modport master (
      output mem_addr, mem_rd, d_inst, run,
      input  mem_rdata, mem_rvalid, done, branch_taken, branch_target
   );

   modport slave (
      input  mem_addr, mem_rd, d_inst, run,
      output mem_rdata, mem_rvalid, done, branch_taken, branch_target
   );

endinterface

// File: rtl/bitty_fetch_ctrl.sv
// Program sequencer for the Bitty cpu: fetch, issue, wait for retire, advance or branch.
// Owns the PC, instruction register, retire counter and the memory-timeout fault.
module bitty_fetch_ctrl
   import bitty_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [INST_W-1:0] HALT_INST   = HALT_INST_DEFAULT,
   parameter int unsigned       MEM_TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      stop,
   bitty_fetch_ctrl_if.master        bus,
   output logic [ADDR_W-1:0]         pc,
   output logic                      busy,
   output logic                      fault,
   output logic [15:0]               retired
);

   // Counter only has to hold MEM_TIMEOUT-1 (4 bits for the default of 15).
   localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(MEM_TIMEOUT - 1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] ir_q, ir_d;
   logic [15:0]       retired_q, retired_d;
   logic              stop_pending_q, stop_pending_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         pc_q           <= RESET_PC;
         ir_q           <= '0;
         retired_q      <= '0;
         stop_pending_q <= 1'b0;
         to_cnt_q       <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         ir_q           <= ir_d;
         retired_q      <= retired_d;
         stop_pending_q <= stop_pending_d;
         to_cnt_q       <= to_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ir_d           = ir_q;
      retired_d      = retired_q;
      stop_pending_d = stop_pending_q;
      to_cnt_d       = to_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start && !stop) state_d = StFetch;
         end
         StFetch: begin
            if (stop) stop_pending_d = 1'b1;
            to_cnt_d = TO_LOAD;
            state_d  = StWaitMem;
         end
         StWaitMem: begin
            if (stop) stop_pending_d = 1'b1;
            if (bus.mem_rvalid) begin
               ir_d = bus.mem_rdata;
               if (bus.mem_rdata == HALT_INST) begin
                  state_d        = StIdle;
                  stop_pending_d = 1'b0;
               end else begin
                  state_d = StIssue;
               end
            end else if (to_cnt_q == '0) begin
               state_d = StFault;
            end else begin
               to_cnt_d = to_cnt_q - TO_W'(1);
            end
         end
         StIssue: begin
            if (stop) stop_pending_d = 1'b1;
            state_d = StExec;
         end
         StExec: begin
            if (stop) stop_pending_d = 1'b1;
            if (bus.done) begin
               retired_d = retired_q + 16'd1;
               pc_d      = bus.branch_taken ? bus.branch_target : pc_q + ADDR_W'(1);
               if (stop_pending_q || stop) begin
                  state_d        = StIdle;
                  stop_pending_d = 1'b0;
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StFault: begin
            // Sticky: only reset leaves this state.
            state_d = StFault;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.mem_addr = pc_q;
   assign bus.mem_rd   = (state_q == StFetch);
   assign bus.run      = (state_q == StIssue);
   assign bus.d_inst   = ir_q;
   assign pc           = pc_q;
   assign busy         = (state_q != StIdle) && (state_q != StFault);
   assign fault        = (state_q == StFault);
   assign retired      = retired_q;

endmodule
